// File: rtl/mul_fac_rot_if.sv
// Stream bundle for mul_fac_rot: input beat handshake, four WIDTH x DEPTH lane
// arrays in each direction, rotation controls and the saturation flag.
interface mul_fac_rot_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        auto_mode;
  logic [1:0]                  rot;
  logic [DEPTH-1:0][WIDTH-1:0] din_R_add;
  logic [DEPTH-1:0][WIDTH-1:0] din_R_sub;
  logic [DEPTH-1:0][WIDTH-1:0] din_Q_add;
  logic [DEPTH-1:0][WIDTH-1:0] din_Q_sub;

  logic                        out_valid;
  logic                        out_ready;
  logic [DEPTH-1:0][WIDTH-1:0] dout_R_add;
  logic [DEPTH-1:0][WIDTH-1:0] dout_R_sub;
  logic [DEPTH-1:0][WIDTH-1:0] dout_Q_add;
  logic [DEPTH-1:0][WIDTH-1:0] dout_Q_sub;
  logic                        out_last;

  logic                        sat_clr;
  logic                        sat_flag;

  modport master (
    output in_valid, auto_mode, rot, din_R_add, din_R_sub, din_Q_add, din_Q_sub,
           out_ready, sat_clr,
    input  in_ready, out_valid, dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub,
           out_last, sat_flag
  );

  modport slave (
    input  in_valid, auto_mode, rot, din_R_add, din_R_sub, din_Q_add, din_Q_sub,
           out_ready, sat_clr,
    output in_ready, out_valid, dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub,
           out_last, sat_flag
  );
endinterface

// File: rtl/mul_fac_rot.sv
// Trivial-twiddle rotator: difference branch of every lane times (-j)^k, sum branch
// passed through, one-deep valid/ready register. MUL_FAC_ROT_SAT_EN enables saturation.
module mul_fac_rot #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int BEATS = 8
) (
  input logic         clk,
  input logic         rst,
  mul_fac_rot_if.slave bus
);

  // At least two bits so beat_cnt[1:0] always exists for automatic rotation.
  localparam int CNT_W = (BEATS > 4) ? $clog2(BEATS) : 2;

  typedef logic [DEPTH-1:0][WIDTH-1:0] lanes_t;

  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       rot_q;
  logic [1:0]       k;
  logic             acc;
  logic             first_beat;
  logic             last_beat;
  lanes_t           rsub_nxt;
  lanes_t           qsub_nxt;

`ifdef MUL_FAC_ROT_SAT_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  // Only -MIN leaves the WIDTH-bit range, so a compare replaces the WIDTH+1 adder.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (x == MIN_VAL) ? MAX_VAL : -x;
  endfunction
`else
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return -x;
  endfunction
`endif

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign first_beat   = (beat_cnt == '0);
  assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));

  // NOTE: every variable written in a combinational block gets a default first so
  // no path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    k = rot_q;
    if (bus.auto_mode)   k = beat_cnt[1:0];
    else if (first_beat) k = bus.rot;
  end

  always_comb begin
    rsub_nxt = '0;
    qsub_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      case (k)
        2'd0: begin
          rsub_nxt[i] = bus.din_R_sub[i];
          qsub_nxt[i] = bus.din_Q_sub[i];
        end
        2'd1: begin
          rsub_nxt[i] = bus.din_Q_sub[i];
          qsub_nxt[i] = negate(bus.din_R_sub[i]);
        end
        2'd2: begin
          rsub_nxt[i] = negate(bus.din_R_sub[i]);
          qsub_nxt[i] = negate(bus.din_Q_sub[i]);
        end
        default: begin
          rsub_nxt[i] = negate(bus.din_Q_sub[i]);
          qsub_nxt[i] = bus.din_R_sub[i];
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      rot_q    <= '0;
    end else if (acc) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (first_beat) rot_q <= bus.rot;
    end
  end

  // NOTE: the wide data registers are reset because the outputs must read zero
  // during and after reset; pure storage would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.dout_R_add <= '0;
      bus.dout_R_sub <= '0;
      bus.dout_Q_add <= '0;
      bus.dout_Q_sub <= '0;
    end else if (acc) begin
      bus.out_valid  <= 1'b1;
      bus.out_last   <= last_beat;
      bus.dout_R_add <= bus.din_R_add;
      bus.dout_R_sub <= rsub_nxt;
      bus.dout_Q_add <= bus.din_Q_add;
      bus.dout_Q_sub <= qsub_nxt;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

`ifdef MUL_FAC_ROT_SAT_EN
  logic sat_hit;

  // Flag only negations that the selected rotation actually uses.
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      case (k)
        2'd1:    sat_hit = sat_hit | (bus.din_R_sub[i] == MIN_VAL);
        2'd2:    sat_hit = sat_hit | (bus.din_R_sub[i] == MIN_VAL)
                                   | (bus.din_Q_sub[i] == MIN_VAL);
        2'd3:    sat_hit = sat_hit | (bus.din_Q_sub[i] == MIN_VAL);
        default: sat_hit = sat_hit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  bus.sat_flag <= 1'b0;
    else if (acc && sat_hit)  bus.sat_flag <= 1'b1;
    else if (bus.sat_clr)     bus.sat_flag <= 1'b0;
  end
`else
  logic sat_clr_unused;
  assign sat_clr_unused = bus.sat_clr;
  assign bus.sat_flag   = 1'b0;
`endif

endmodule
